// File: rtl/usb4_tc_noc_fifo_ctrl_8_35.sv
`default_nettype none
// ============================================================================
// Module   : usb4_tc_noc_fifo_ctrl_8_35
// Purpose  : Control and handshake front-end for the ingress 8 x 35 two-port
//            RAM buffer. Keeps wrap-bit write/read pointers and occupancy,
//            offers a valid/ready push port and a first-word-fall-through
//            valid/ready pop port, and drives the RAM write/read ports.
//            The RAM writes synchronously and reads asynchronously.
// Ports    : clk, rst_n (async, active-low), flush (sync clear)
//            wr_valid / wr_ready / wr_data     - producer push interface
//            rd_valid / rd_ready / rd_data     - consumer pop interface (FWFT)
//            count, almost_full                - occupancy status
//            ram_wen / ram_waddr / ram_wdata   - RAM write port
//            ram_ren / ram_raddr / ram_rdata   - RAM read port
// Revision : 1.0 - initial release
// ============================================================================
module usb4_tc_noc_fifo_ctrl_8_35 #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 35,
  parameter int AW        = 3,
  parameter int AFULL_THR = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             almost_full,
  output logic             ram_wen,
  output logic [AW-1:0]    ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_ren,
  output logic [AW-1:0]    ram_raddr,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam logic [AW:0] c_one       = (AW+1)'(1);
  localparam logic [AW:0] c_afull_thr = (AW+1)'(AFULL_THR);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [AW:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  // Full: same address, opposite lap (wrap bit differs).
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

  // Ready/valid come only from registered state, so no combinational path
  // from wr_valid/rd_ready. No pop-through when full.
  assign wr_ready = !w_full;
  assign rd_valid = !w_empty;

  assign w_push = wr_valid & wr_ready & !flush;
  assign w_pop  = rd_valid & rd_ready & !flush;

  assign rd_data     = ram_rdata;
  assign ram_raddr   = r_rptr[AW-1:0];
  assign ram_ren     = rd_valid;
  assign ram_wen     = w_push;
  assign ram_waddr   = r_wptr[AW-1:0];
  assign ram_wdata   = wr_data;

  assign count       = r_count;
  assign almost_full = (r_count >= c_afull_thr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      // Flush wins over any handshake in the same cycle; RAM is left as is.
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb4_tc_noc_fifo_ctrl_8_35.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb4_tc_noc_fifo_ctrl_8_35
// Purpose  : Self-checking bench for the ingress FIFO controller. Models the
//            two-port RAM (sync write, async read), applies a table of
//            directed vectors for fill/drain, then hand-written sequences
//            for wrap, full-plus-pop, flush and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb4_tc_noc_fifo_ctrl_8_35;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        wr_valid;
  logic        wr_ready;
  logic [34:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [34:0] rd_data;
  logic [3:0]  count;
  logic        almost_full;
  logic        ram_wen;
  logic [2:0]  ram_waddr;
  logic [34:0] ram_wdata;
  logic        ram_ren;
  logic [2:0]  ram_raddr;
  logic [34:0] ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  usb4_tc_noc_fifo_ctrl_8_35 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .count       (count),
    .almost_full (almost_full),
    .ram_wen     (ram_wen),
    .ram_waddr   (ram_waddr),
    .ram_wdata   (ram_wdata),
    .ram_ren     (ram_ren),
    .ram_raddr   (ram_raddr),
    .ram_rdata   (ram_rdata)
  );

  // Two-port RAM model: synchronous write, asynchronous read.
  logic [34:0] mem [8];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol watchdog: a write must only happen on an accepted push.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      n_checks++;
      if (ram_wen && (!wr_ready || !wr_valid || flush)) begin
        n_fail++;
        $display("FAIL illegal_write actual wen=%b ready=%b valid=%b flush=%b required no write",
                 ram_wen, wr_ready, wr_valid, flush);
      end
      n_checks++;
      if (count > 4'd8) begin
        n_fail++;
        $display("FAIL count_range actual=%0d required<=8", count);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then settle to the falling edge
  // where outputs are sampled.
  task automatic step(input logic f, input logic wv, input logic rr, input logic [34:0] wd);
    @(posedge clk);
    #1;
    flush    = f;
    wr_valid = wv;
    rd_ready = rr;
    wr_data  = wd;
    @(negedge clk);
  endtask

  typedef struct {
    logic        flush;
    logic        wv;
    logic        rr;
    logic [34:0] wd;
    logic        e_wr_ready;
    logic        e_rd_valid;
    logic        e_afull;
    logic        e_wen;
    logic        e_chk_data;
    logic [3:0]  e_count;
    logic [34:0] e_rd_data;
  } vec_t;

  vec_t vt [18];

  initial begin
    rst_n    = 1'b1;
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    wr_data  = '0;

    // Fill: 8 pushes of 1..8, rd_ready low. Expectations are the outputs
    // seen during each cycle, before its closing edge.
    for (int i = 0; i < 8; i++) begin
      vt[i] = '{flush:1'b0, wv:1'b1, rr:1'b0, wd:35'(i + 1),
                e_wr_ready:1'b1, e_rd_valid:(i > 0), e_afull:(i >= 6), e_wen:1'b1,
                e_chk_data:(i > 0), e_count:4'(i), e_rd_data:35'd1};
    end
    // 9th offer while full: held off.
    vt[8] = '{flush:1'b0, wv:1'b1, rr:1'b0, wd:35'd9,
              e_wr_ready:1'b0, e_rd_valid:1'b1, e_afull:1'b1, e_wen:1'b0,
              e_chk_data:1'b1, e_count:4'd8, e_rd_data:35'd1};
    // Drain: heads 1..8 on consecutive cycles.
    for (int k = 0; k < 8; k++) begin
      vt[9 + k] = '{flush:1'b0, wv:1'b0, rr:1'b1, wd:35'd0,
                    e_wr_ready:(k > 0), e_rd_valid:1'b1, e_afull:(k <= 2), e_wen:1'b0,
                    e_chk_data:1'b1, e_count:4'(8 - k), e_rd_data:35'(k + 1)};
    end
    vt[17] = '{flush:1'b0, wv:1'b0, rr:1'b0, wd:35'd0,
               e_wr_ready:1'b1, e_rd_valid:1'b0, e_afull:1'b0, e_wen:1'b0,
               e_chk_data:1'b0, e_count:4'd0, e_rd_data:35'd0};

    // ---------------- Reset ----------------
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_afull", 64'(almost_full), 64'd0);
    chk("rst_wen", 64'(ram_wen), 64'd0);
    chk("rst_ren", 64'(ram_ren), 64'd0);
    chk("rst_waddr", 64'(ram_waddr), 64'd0);
    chk("rst_raddr", 64'(ram_raddr), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- Table: fill and drain ----------------
    for (int v = 0; v < 18; v++) begin
      step(vt[v].flush, vt[v].wv, vt[v].rr, vt[v].wd);
      chk($sformatf("v%0d_wr_ready", v), 64'(wr_ready), 64'(vt[v].e_wr_ready));
      chk($sformatf("v%0d_rd_valid", v), 64'(rd_valid), 64'(vt[v].e_rd_valid));
      chk($sformatf("v%0d_count", v), 64'(count), 64'(vt[v].e_count));
      chk($sformatf("v%0d_afull", v), 64'(almost_full), 64'(vt[v].e_afull));
      chk($sformatf("v%0d_wen", v), 64'(ram_wen), 64'(vt[v].e_wen));
      if (vt[v].e_chk_data)
        chk($sformatf("v%0d_rd_data", v), 64'(rd_data), 64'(vt[v].e_rd_data));
    end

    // ---------------- Wrap: count held at 3 ----------------
    // Pointers sit at 8/8 (address 0) after the fill/drain pass.
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 1'b1, 1'b0, 35'(100 + j));
      chk("wrap_pre_waddr", 64'(ram_waddr), 64'(j));
    end
    for (int j = 0; j < 20; j++) begin
      step(1'b0, 1'b1, 1'b1, 35'(103 + j));
      chk($sformatf("wrap%0d_count", j), 64'(count), 64'd3);
      chk($sformatf("wrap%0d_data", j), 64'(rd_data), 64'(100 + j));
      chk($sformatf("wrap%0d_waddr", j), 64'(ram_waddr), 64'((3 + j) % 8));
      chk($sformatf("wrap%0d_raddr", j), 64'(ram_raddr), 64'(j % 8));
      chk($sformatf("wrap%0d_wen", j), 64'(ram_wen), 64'd1);
    end
    // Queue now holds 120,121,122.

    // ---------------- Full plus pop ----------------
    for (int j = 0; j < 5; j++) step(1'b0, 1'b1, 1'b0, 35'(200 + j));
    step(1'b0, 1'b1, 1'b1, 35'd205);
    chk("fp_count8", 64'(count), 64'd8);
    chk("fp_wr_ready0", 64'(wr_ready), 64'd0);
    chk("fp_wen0", 64'(ram_wen), 64'd0);
    chk("fp_head", 64'(rd_data), 64'd120);
    step(1'b0, 1'b1, 1'b0, 35'd205);
    chk("fp_count7", 64'(count), 64'd7);
    chk("fp_wen1", 64'(ram_wen), 64'd1);
    chk("fp_head2", 64'(rd_data), 64'd121);
    step(1'b0, 1'b0, 1'b0, 35'd0);
    chk("fp_count8b", 64'(count), 64'd8);
    chk("fp_wr_ready_b", 64'(wr_ready), 64'd0);

    // ---------------- Flush at count 5 ----------------
    step(1'b0, 1'b0, 1'b1, 35'd0);
    chk("fl_pop0", 64'(rd_data), 64'd121);
    step(1'b0, 1'b0, 1'b1, 35'd0);
    chk("fl_pop1", 64'(rd_data), 64'd122);
    step(1'b0, 1'b0, 1'b1, 35'd0);
    chk("fl_pop2", 64'(rd_data), 64'd200);
    step(1'b1, 1'b1, 1'b1, 35'h123);
    chk("fl_count5", 64'(count), 64'd5);
    chk("fl_wen0", 64'(ram_wen), 64'd0);
    step(1'b0, 1'b1, 1'b0, 35'h7_FFFF_FFFF);
    chk("fl_count0", 64'(count), 64'd0);
    chk("fl_rd_valid0", 64'(rd_valid), 64'd0);
    chk("fl_waddr0", 64'(ram_waddr), 64'd0);
    chk("fl_wen1", 64'(ram_wen), 64'd1);
    step(1'b0, 1'b0, 1'b0, 35'd0);
    chk("fl_rd_valid1", 64'(rd_valid), 64'd1);
    chk("fl_raddr0", 64'(ram_raddr), 64'd0);
    chk("fl_data", 64'(rd_data), 64'h7_FFFF_FFFF);
    step(1'b0, 1'b0, 1'b1, 35'd0);
    step(1'b0, 1'b0, 1'b0, 35'd0);
    chk("fl_drained", 64'(count), 64'd0);

    // ---------------- Async reset mid-stream ----------------
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 1'b0, 35'(300 + j));
    step(1'b0, 1'b0, 1'b0, 35'd0);
    chk("ar_count4", 64'(count), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_rd_valid", 64'(rd_valid), 64'd0);
    chk("ar_wr_ready", 64'(wr_ready), 64'd1);
    chk("ar_ren", 64'(ram_ren), 64'd0);
    chk("ar_raddr", 64'(ram_raddr), 64'd0);
    chk("ar_waddr", 64'(ram_waddr), 64'd0);
    chk("ar_wen", 64'(ram_wen), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 35'h4242);
    chk("ar_push_rd_valid", 64'(rd_valid), 64'd0);
    chk("ar_push_wen", 64'(ram_wen), 64'd1);
    chk("ar_push_waddr", 64'(ram_waddr), 64'd0);
    step(1'b0, 1'b0, 1'b0, 35'd0);
    chk("ar_vis_rd_valid", 64'(rd_valid), 64'd1);
    chk("ar_vis_data", 64'(rd_data), 64'h4242);
    chk("ar_vis_count", 64'(count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/usb4_tc_noc_fifo_ctrl_8_35.md
# usb4_tc_noc_fifo_ctrl_8_35

Control and handshake front-end for the 8-entry × 35-bit two-port RAM buffer in the link ingress path (ls_g2l r0 FIFO). It drives the RAM's write and read ports through `ram_*` signals and keeps write/read pointers, occupancy and flags. It presents a valid/ready push interface to the producer and a first-word-fall-through valid/ready pop interface to the consumer. The RAM has a synchronous write and an asynchronous read.

## Interface
- `DEPTH`, default 8: number of entries; must be a power of two.
- `WIDTH`, default 35: data width in bits.
- `AW`, default 3: address width, equal to log2(DEPTH).
- `AFULL_THR`, default 6: `almost_full` asserts when occupancy ≥ this value.
- `clk`  in  1: single clock for the whole block.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `flush`  in  1: synchronous clear of all contents.
- `wr_valid`  in  1: producer offers `wr_data`.
- `wr_ready`  out  1: the FIFO can accept a push.
- `wr_data`  in  WIDTH: push data.
- `rd_valid`  out  1: head entry is available.
- `rd_ready`  in  1: consumer takes the head entry.
- `rd_data`  out  WIDTH: head entry data.
- `count`  out  AW+1: occupancy, 0..DEPTH.
- `almost_full`  out  1: `count` ≥ `AFULL_THR`.
- `ram_wen`  out  1: RAM write enable.
- `ram_waddr`  out  AW: RAM write address.
- `ram_wdata`  out  WIDTH: RAM write data.
- `ram_ren`  out  1: RAM read enable.
- `ram_raddr`  out  AW: RAM read address.
- `ram_rdata`  in  WIDTH: RAM read data, combinational from `ram_raddr`.

## Operation
**State**
- `wptr` and `rptr` are registered, AW+1 bits each; the MSB is the wrap bit.
- `count` is registered.

**Flags and handshake**
- `empty`: `wptr == rptr`.
- `full`: address bits are equal and wrap bits differ.
- `push` = `wr_valid & wr_ready & !flush`.
- `pop` = `rd_valid & rd_ready & !flush`.
- `wr_ready` = `!full`. There is no pop-through when full: a push in the same cycle as a pop at `count`=DEPTH is not accepted.
- `rd_valid` = `!empty`.

**Datapath to the RAM**
- `rd_data` = `ram_rdata`.
- `ram_raddr` = `rptr[AW-1:0]`.
- `ram_ren` = `rd_valid`.
- `ram_wen` = `push`.
- `ram_waddr` = `wptr[AW-1:0]`.
- `ram_wdata` = `wr_data`.

**Pointer and count update**
- On `push`, `wptr` increments by 1 modulo 2^(AW+1).
- On `pop`, `rptr` increments by 1 modulo 2^(AW+1).
- `count` updates as `count` + `push` − `pop`.
- A simultaneous `push` and `pop` leaves `count` unchanged.
- Address wrap from 7 to 0 toggles the wrap bit.

**Flush**
- Has priority over push and pop.
- Next cycle: `wptr` = `rptr` = 0 and `count` = 0.
- `ram_wen` is 0 in the flush cycle. RAM contents are not cleared.

**Handshake rules**
- A producer holding `wr_valid` must keep `wr_data` stable until `wr_ready`.
- `rd_data` is stable while `rd_valid=1` and no pop occurs.
- A pop when empty and a push when full are impossible by construction. Bench assertions check both never happen.

**Reset (`rst_n` low, asynchronous)**
- `wptr` = `rptr` = 0, `count` = 0.
- Outputs: `rd_valid`=0, `wr_ready`=1, `almost_full`=0, `ram_wen`=0, `ram_ren`=0, `ram_waddr`=0, `ram_raddr`=0.
- Reset mid-operation discards all entries; no partial state survives.

## Timing
- Push to visible: an entry pushed at edge N gives `rd_valid`=1 from cycle N+1 (RAM write lands at edge N). Minimum latency is 1 cycle; there is no same-cycle bypass.
- Pop: combinational on `rd_ready`. The next head appears on `rd_data` in the cycle after the pop edge.
- `full`, `empty` and `almost_full` are derived from registered pointers and `count`; they do not depend combinationally on `wr_valid` or `rd_ready`.
- `wr_ready` and `rd_valid` do not depend combinationally on `wr_valid` or `rd_ready`.
- Sustained throughput is 1 push and 1 pop per cycle when 0 < `count` < DEPTH.

## Test plan
- **Reset then fill:** after reset, push 8 words 0x0_0000_0001..0x0_0000_0008 back-to-back with `rd_ready`=0.
  - `count` steps 1..8.
  - `almost_full` rises on the cycle `count` becomes 6.
  - `wr_ready`=0 at `count`=8.
  - A 9th `wr_valid` is held off with `ram_wen`=0.
- **Drain in order:** from full, hold `rd_ready`=1.
  - `rd_data` reads 1..8 on consecutive cycles.
  - `rd_valid` falls after the 8th pop; `count`=0.
- **Wrap:** 20 streaming push/pop pairs with `count` held at 3.
  - Data comes out in order.
  - Pointers wrap through address 7→0 twice.
  - `count` stays 3.
- **Full plus pop:** at `count`=8 assert `wr_valid` and `rd_ready` together.
  - Pop accepted, push rejected; `count`=7 next cycle.
  - The push is accepted in the following cycle; `count`=8.
- **Flush:** at `count`=5 assert `flush` with `wr_valid`=`rd_ready`=1.
  - Next cycle `count`=0, `rd_valid`=0.
  - No `ram_wen` in the flush cycle.
  - The next push of 0x7_FFFF_FFFF reads back correctly.
- **Async reset mid-stream:** drop `rst_n` between edges at `count`=4.
  - Outputs take their reset values immediately, without waiting for a clock edge.
  - After release, the first push appears with 1-cycle latency.
